// File: rtl/mult_share_arb_pkg.sv
// Shared widths, operand/product types and the round-robin pointer helper
// used by the shared-multiplier arbiter.
package mult_arb_pkg;
  localparam int OPW = 16;
  localparam int PW  = 32;

  typedef logic [OPW-1:0] op_t;
  typedef logic [PW-1:0]  prod_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/R4ABM2p14.sv
// Radix-4 Booth approximate 16x16 unsigned multiplier: negative partial
// products in the 14 least significant columns omit their +1 correction.
module R4ABM2p14
  import mult_arb_pkg::*;
(
  input  op_t   x,
  input  op_t   y,
  output prod_t p
);
  localparam int APPROX_COLS = 14;
  localparam int NDIG = OPW / 2 + 1;

  logic [OPW+2:0] y_ext;
  logic [2:0]     b;
  logic           neg;
  logic [OPW:0]   m;
  prod_t          mag;
  prod_t          acc;

  assign y_ext = {2'b00, y, 1'b0};

  always_comb begin
    acc = '0;
    b   = '0;
    neg = 1'b0;
    m   = '0;
    mag = '0;
    for (int j = 0; j < NDIG; j++) begin
      b   = y_ext[2*j +: 3];
      neg = b[2] & ~(b[1] & b[0]);
      case (b)
        3'b001, 3'b010, 3'b101, 3'b110: m = {1'b0, x};
        3'b011, 3'b100:                 m = {x, 1'b0};
        default:                        m = '0;
      endcase
      mag = PW'(m) << (2 * j);
      // Zero magnitude stays zero even for a negative digit.
      if (neg && (m != '0))
        acc = acc + ~mag + ((j >= APPROX_COLS / 2) ? 32'd1 : 32'd0);
      else
        acc = acc + mag;
    end
    p = acc;
  end
endmodule

// File: rtl/mult_share_arb_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(ptr) + off) % NREQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDW'(cand);
      end
    end
  end
endmodule

// File: rtl/mult_share_arb.sv
// One R4ABM2p14 shared by NREQ valid/ready requesters with a tagged result
// channel. Define MULT_STAGE2_EN for an extra product register (3-edge latency).
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*OPW-1:0] req_x,
  input  logic [NREQ*OPW-1:0] req_y,
  output logic              res_valid,
  input  logic              res_ready,
  output prod_t             res_p,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);
  // Handshake: a transfer happens on an edge where valid & ready are both high;
  // ready never waits on valid of the same requester being dropped.
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx, rr_ptr, s1_id, src_id;
  logic            gnt_any, hs, adv, feed_adv, s1_free, s1_v, out_v, src_v;
  op_t             x_vec, y_vec;
  prod_t           p_vec, src_p;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  R4ABM2p14 u_mult (.x(x_vec), .y(y_vec), .p(p_vec));

  assign adv = !out_v | res_ready;

`ifdef MULT_STAGE2_EN
  logic           s2_v;
  prod_t          s2_p;
  logic [IDW-1:0] s2_id;

  assign feed_adv = adv | !s2_v;
  assign src_v    = s2_v;
  assign src_p    = s2_p;
  assign src_id   = s2_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v  <= 1'b0;
      s2_p  <= '0;
      s2_id <= '0;
    end else if (feed_adv) begin
      s2_v  <= s1_v;
      s2_p  <= p_vec;
      s2_id <= s1_id;
    end
  end

  assign busy = s1_v | s2_v | out_v;
`else
  assign feed_adv = adv;
  assign src_v    = s1_v;
  assign src_p    = p_vec;
  assign src_id   = s1_id;
  assign busy     = s1_v | out_v;
`endif

  assign s1_free   = feed_adv | !s1_v;
  assign hs        = gnt_any & s1_free & !rst;
  assign req_ready = hs ? gnt : '0;
  assign res_valid = out_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      s1_v   <= 1'b0;
      s1_id  <= '0;
      x_vec  <= '0;
      y_vec  <= '0;
    end else if (hs) begin
      rr_ptr <= IDW'(rr_next(int'(gnt_idx), NREQ));
      s1_v   <= 1'b1;
      s1_id  <= gnt_idx;
      x_vec  <= req_x[gnt_idx*OPW +: OPW];
      y_vec  <= req_y[gnt_idx*OPW +: OPW];
    end else if (feed_adv) begin
      s1_v <= 1'b0;
    end
  end

  // Data only moves with a valid source so an idle OUT keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      res_p  <= '0;
      res_id <= '0;
    end else if (adv) begin
      out_v <= src_v;
      if (src_v) begin
        res_p  <= src_p;
        res_id <= src_id;
      end
    end
  end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one R4ABM2p14 approximate 16x16 multiplier between NREQ requesters.
- Each requester presents operands over a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and registers its operands into the multiplier inputs.
- The registered product is returned on a single tagged result channel with backpressure; this block replaces per-client mult_top wrappers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester ID tag.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle, one-hot or zero.
- req_x  in  NREQ*16  multiplicand; requester i uses bits [16i+15:16i].
- req_y  in  NREQ*16  multiplier; same packing as req_x.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_p  out  32  product from R4ABM2p14.
- res_id  out  IDW  index of the requester that owns res_p.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - s1_v=0, out_v (res_valid)=0, res_p=0, res_id=0, rr_ptr=0.
  - Operand registers X_vec, Y_vec = 0.
  - rst overrides every other event, including a mid-flight result; in-flight data is dropped.
- Pipeline:
  - Stage S1 holds X_vec, Y_vec and s1_id with valid bit s1_v. These registers feed R4ABM2p14, which is combinational.
  - Stage OUT holds res_p, res_id and out_v.
- Advance rule: adv = !out_v | res_ready.
  - OUT loads {P_vec, s1_id} and takes out_v=s1_v when adv.
  - S1 can load when s1_free = adv | !s1_v.
- Arbitration (round-robin):
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ; first set bit is grant g.
  - req_ready[i] = (i==g) & req_valid[i] & s1_free. At most one bit is high.
  - req_ready may depend combinationally on req_valid and res_ready. Requesters must not make req_valid depend on req_ready.
  - On handshake (req_valid[g] & req_ready[g]): S1 loads req_x/req_y slice g, s1_id=g, s1_v=1, and rr_ptr becomes (g+1) mod NREQ.
  - No handshake: rr_ptr holds. If adv, s1_v clears.
- Latency and throughput:
  - Handshake at edge k gives res_valid=1 after edge k+1 (2 edges, matching mult_top's in/out registering).
  - Throughput is 1 result/cycle when res_ready stays high.
- Stall: with res_valid=1 and res_ready=0, res_p, res_id and res_valid hold stable. S1 holds; a new request is accepted only if S1 is empty. Maximum occupancy is 2.
- Simultaneous events:
  - With res_ready=1 and out_v=1, OUT drains and reloads from S1 in the same edge. S1 accepts a new request in that same edge.
- Fairness: a continuously-valid requester waits at most NREQ-1 grants.
- Data rules:
  - Operands are unsigned 16-bit; product width is 32.
  - Data is not checked or altered; the approximation error belongs to R4ABM2p14.
- busy = s1_v | out_v.

Optional Feature:
- Macro: MULT_STAGE2_EN.
- Defined:
  - An extra register stage S2 (P_vec, id, valid) sits between the multiplier and OUT, for timing closure.
  - Latency becomes 3 edges.
  - The same adv chaining applies: S2 loads when OUT is free or empty. Maximum occupancy becomes 3.
  - busy also includes s2_v.
- Undefined: exactly the 2-edge behaviour above.

Decomposition:
- Package mult_arb_pkg:
  - OPW=16, PW=32.
  - Function rr_next(ptr, n).
  - Typedef op_t = logic [OPW-1:0]; typedef prod_t = logic [PW-1:0].
- Sub-module rr_arbiter (NREQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational; rr_ptr lives in mult_share_arb.
- R4ABM2p14 is instantiated unchanged, once.

Test Plan:
- Reset check: assert rst for 2 cycles with all req_valid=1 -> req_ready=0 during reset, then res_valid=0, res_p=0, busy=0; first grant after release goes to requester 0.
- Single request: req 2 with x=16'h0000, y=16'hFFFF, res_ready=1 -> res_valid after 2 edges, res_p=0, res_id=2. Then x=16'h0003, y=16'h0005 -> res_p equals the golden R4ABM2p14 model.
- Round-robin: all 4 req_valid held high for 8 cycles with res_ready=1 -> grant order 0,1,2,3,0,1,2,3; res_id follows the same sequence 2 edges later; 1 result/cycle.
- Backpressure: res_ready=0 for 5 cycles while reqs 1 and 3 are valid -> exactly 2 handshakes accepted; res_p/res_id stable; req_ready=0 after S1 fills. Releasing res_ready drains id 1 then id 3 with no loss or duplication.
- Reset mid-operation: rst pulse while s1_v=1 and out_v=1 -> the next cycle shows res_valid=0, busy=0, rr_ptr=0; dropped results never appear.
- MULT_STAGE2_EN build: repeat the round-robin and backpressure scenarios -> latency 3 edges, occupancy ≤3, identical result values and ID order.
